// File: rtl/kernel_top_buff_flush_ctrl.sv
// Purpose: job controller that feeds N items through an external DEPTH-beat offset buffer, then flushes it with bubbles.
// Latency: item k leaves on push k+DEPTH. done pulses one cycle after the final flush push.
// Backpressure: pushes happen only with m_ready. RUN also needs s_valid. A stall freezes state and all counters.
module kernel_top_buff_flush_ctrl #(
    parameter int STREAMW  = 32,
    parameter int DEPTH    = 3,
    parameter int NITEMS_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NITEMS_W-1:0] nitems,
    output logic                busy,
    output logic                done,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [STREAMW-1:0]  s_data,
    output logic                b_ivalid,
    output logic [STREAMW-1:0]  b_data,
    input  logic                b_ovalid,
    input  logic [STREAMW-1:0]  b_odata,
    output logic                b_clr,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [STREAMW-1:0]  m_data,
    output logic                m_last
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [NITEMS_W-1:0] FLUSH_LAST = NITEMS_W'(DEPTH - 1);

    state_t              state;
    logic [NITEMS_W-1:0] nitems_q;
    logic [NITEMS_W-1:0] in_cnt;
    logic [NITEMS_W-1:0] out_cnt;
    logic [NITEMS_W-1:0] flush_cnt;
    logic [NITEMS_W-1:0] last_idx;
    logic                b_clr_q;
    logic                push_ok;
    logic                push;
    logic                m_xfer;

    // Push path. The buffer shifts on every strobe, so a push is only allowed
    // when downstream can take whatever falls out of the tap.
    always_comb begin
        s_ready  = 1'b0;
        b_ivalid = 1'b0;
        b_data   = '0;
        push_ok  = 1'b0;
        case (state)
            RUN: begin
                s_ready  = m_ready;
                b_ivalid = s_valid & m_ready;
                b_data   = s_data;
                push_ok  = s_valid;
            end
            FLUSH: begin
                b_ivalid = m_ready;
                push_ok  = 1'b1;
            end
            default: begin
                s_ready  = 1'b0;
                b_ivalid = 1'b0;
            end
        endcase
    end

    // The tap is only offered on cycles that would push. A stalled beat
    // therefore cannot be consumed while the buffer is not shifting.
    assign push     = b_ivalid;
    assign m_valid  = b_ovalid & push_ok;
    assign m_data   = b_odata;
    assign m_xfer   = m_valid & m_ready;
    assign last_idx = nitems_q - NITEMS_W'(1);
    assign m_last   = m_valid & (out_cnt == last_idx);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign b_clr    = b_clr_q | done;

    // b_clr holds through reset and drops on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_clr_q <= 1'b1;
        end else begin
            b_clr_q <= 1'b0;
        end
    end

    // Job FSM and item counters. Every counter only moves on a real push or transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            nitems_q  <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (nitems != '0) begin
                            nitems_q  <= nitems;
                            in_cnt    <= '0;
                            out_cnt   <= '0;
                            flush_cnt <= '0;
                            state     <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (push) begin
                        in_cnt <= in_cnt + NITEMS_W'(1);
                        if (in_cnt == last_idx) begin
                            state <= FLUSH;
                        end
                    end
                    if (m_xfer) begin
                        out_cnt <= out_cnt + NITEMS_W'(1);
                    end
                end
                FLUSH: begin
                    if (push) begin
                        flush_cnt <= flush_cnt + NITEMS_W'(1);
                        if (flush_cnt == FLUSH_LAST) begin
                            state <= DONE;
                        end
                    end
                    if (m_xfer) begin
                        out_cnt <= out_cnt + NITEMS_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_top_buff_flush_ctrl.sv
// Bench for kernel_top_buff_flush_ctrl with a behavioural offset buffer and an output scoreboard.
// The scoreboard is filled on accepted input beats and drained by the output monitor.
// Directed jobs cover steady flow, short jobs, alternating m_ready, empty jobs, mid-job reset and start spam.
module tb_kernel_top_buff_flush_ctrl;

    localparam int STREAMW  = 32;
    localparam int DEPTH    = 3;
    localparam int NITEMS_W = 16;

    logic                clk;
    logic                rst;
    logic                start;
    logic [NITEMS_W-1:0] nitems;
    logic                busy;
    logic                done;
    logic                s_valid;
    logic                s_ready;
    logic [STREAMW-1:0]  s_data;
    logic                b_ivalid;
    logic [STREAMW-1:0]  b_data;
    logic                b_ovalid;
    logic [STREAMW-1:0]  b_odata;
    logic                b_clr;
    logic                m_valid;
    logic                m_ready;
    logic [STREAMW-1:0]  m_data;
    logic                m_last;

    kernel_top_buff_flush_ctrl #(
        .STREAMW (STREAMW),
        .DEPTH   (DEPTH),
        .NITEMS_W(NITEMS_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .nitems  (nitems),
        .busy    (busy),
        .done    (done),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .b_ivalid(b_ivalid),
        .b_data  (b_data),
        .b_ovalid(b_ovalid),
        .b_odata (b_odata),
        .b_clr   (b_clr),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offset buffer: shifts on every push, synchronous clear, tap at the last stage.
    logic [STREAMW-1:0] bd [DEPTH];
    logic               bv [DEPTH];
    always @(posedge clk) begin
        if (b_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                bv[i] <= 1'b0;
                bd[i] <= '0;
            end
        end else if (b_ivalid) begin
            bv[0] <= 1'b1;
            bd[0] <= b_data;
            for (int i = 1; i < DEPTH; i++) begin
                bv[i] <= bv[i-1];
                bd[i] <= bd[i-1];
            end
        end
    end
    assign b_ovalid = bv[DEPTH-1];
    assign b_odata  = bd[DEPTH-1];

    typedef struct packed {
        logic [STREAMW-1:0] dat;
        logic               last;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   push_cnt, out_seen, busy_cyc, last_push_cyc, done_cyc, first_out_push;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: drains the scoreboard and records push and done timing.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (busy) busy_cyc++;
        if (done) done_cyc = cyc;
        if (b_ivalid) begin
            push_cnt++;
            last_push_cyc = cyc;
            chk("push_needs_m_ready", {63'd0, m_ready}, 64'd1);
        end
        if (m_valid && m_ready) begin
            chk("output_was_expected", {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                out_seen++;
                if (out_seen == 1) first_out_push = push_cnt;
                chk("m_data", {32'd0, m_data}, {32'd0, e.dat});
                chk("m_last", {63'd0, m_last}, {63'd0, e.last});
            end
        end
    end

    task automatic run_job(input int n, input int base, input bit alt_ready, input bit spam);
        bit done_seen;
        int idx;
        int t;
        int done_t;
        push_cnt       = 0;
        out_seen       = 0;
        busy_cyc       = 0;
        last_push_cyc  = -1;
        done_cyc       = -1;
        first_out_push = -1;
        done_seen      = 1'b0;
        done_t         = -1;
        idx            = 0;
        t              = 0;
        start  = 1'b1;
        nitems = NITEMS_W'(n);
        @(posedge clk);
        #1;
        start  = spam;
        nitems = spam ? NITEMS_W'(2) : NITEMS_W'(n);
        while (!done_seen && t < 400) begin
            s_valid = (idx < n);
            s_data  = STREAMW'(base + idx);
            m_ready = alt_ready ? (t % 2 == 0) : 1'b1;
            @(negedge clk);
            if (s_valid && s_ready) begin
                sb.push_back('{dat: STREAMW'(base + idx), last: (idx == n - 1)});
                idx++;
            end
            if (done) begin
                done_seen = 1'b1;
                done_t    = t;
            end
            @(posedge clk);
            #1;
            t++;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("done_within_budget", {63'd0, done_seen}, 64'd1);
        chk("items_out", 64'(out_seen), 64'(n));
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        chk("idle_after_done", {63'd0, busy}, 64'd0);
        if (n > 0) begin
            chk("push_count", 64'(push_cnt), 64'(n + DEPTH));
            chk("done_after_last_push", 64'(done_cyc), 64'(last_push_cyc + 1));
            chk("first_out_push", 64'(first_out_push), 64'(DEPTH + 1));
        end else begin
            chk("empty_job_pushes", 64'(push_cnt), 64'd0);
            chk("empty_job_busy_cycles", 64'(busy_cyc), 64'd1);
            chk("empty_job_done_cycle", 64'(done_t), 64'd0);
        end
        sb.delete();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_b_ivalid", {63'd0, b_ivalid}, 64'd0);
        chk("rst_m_last", {63'd0, m_last}, 64'd0);
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_b_data", {32'd0, b_data}, 64'd0);
        chk("rst_b_clr", {63'd0, b_clr}, 64'd1);
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        nitems  = '0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b1;
        #1;
        chk("b_clr_held_until_edge", {63'd0, b_clr}, 64'd1);
        @(posedge clk);
        #1;
        chk("b_clr_released", {63'd0, b_clr}, 64'd0);

        run_job(5, 1, 1'b0, 1'b0);
        run_job(2, 'hA, 1'b0, 1'b0);
        run_job(6, 1, 1'b1, 1'b0);
        run_job(0, 0, 1'b0, 1'b0);

        // Abandon a 10-item job part way through RUN.
        start  = 1'b1;
        nitems = NITEMS_W'(10);
        @(posedge clk);
        #1;
        start   = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = STREAMW'(100 + i);
            @(negedge clk);
            if (s_valid && s_ready) sb.push_back('{dat: STREAMW'(100 + i), last: 1'b0});
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        sb.delete();
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("b_clr_after_midjob_reset", {63'd0, b_clr}, 64'd0);
        run_job(4, 'h200, 1'b0, 1'b0);

        run_job(5, 'h300, 1'b0, 1'b1);
        run_job(1, 'h400, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kernel_top_buff_flush_ctrl.md
KERNEL_TOP_BUFF_FLUSH_CTRL -- requirements
Module: kernel_top_buff_flush_ctrl

Interface
REQ-001 Parameter STREAMW, default 32, data width of the stream words.
REQ-002 Parameter DEPTH, default 3, delay in beats of the controlled offset buffer (DEPTH >= 1).
REQ-003 Parameter NITEMS_W, default 16, width of the job length and of all item counters.
REQ-004 clk  input  1  single clock; all registers on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  job start request; sampled only in IDLE.
REQ-007 nitems  input  NITEMS_W  job length in items; latched when start is accepted.
REQ-008 busy  output  1  high in RUN, FLUSH and DONE.
REQ-009 done  output  1  one-cycle pulse at job end.
REQ-010 s_valid / s_ready / s_data  input / output / input  1 / 1 / STREAMW  upstream stream.
REQ-011 b_ivalid / b_data  output / output  1 / STREAMW  push strobe and data to the offset buffer.
REQ-012 b_ovalid / b_odata  input / input  1 / STREAMW  valid and data tapped from the offset buffer.
REQ-013 b_clr  output  1  active-high synchronous clear to the offset buffer.
REQ-014 m_valid / m_ready / m_data / m_last  output / input / output / output  1 / 1 / STREAMW / 1  downstream stream.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, RUN, FLUSH, DONE.
REQ-016 IDLE: start=1 and nitems!=0 -> latch nitems, clear in_cnt, out_cnt, flush_cnt -> RUN; start=1 and nitems=0 -> DONE; otherwise stay.
REQ-017 The buffer shifts on every b_ivalid regardless of its ready, so a push SHALL occur only when m_ready=1.
REQ-018 RUN: s_ready = m_ready; b_ivalid = s_valid & m_ready; b_data = s_data; in_cnt increments on each push.
REQ-019 RUN: push while in_cnt = nitems-1 -> FLUSH.
REQ-020 FLUSH: s_ready=0; b_ivalid = m_ready; b_data = 0 (bubble); flush_cnt increments on each push.
REQ-021 FLUSH: push while flush_cnt = DEPTH-1 -> DONE; a FLUSH of exactly DEPTH pushes SHALL occur for every job, including nitems < DEPTH.
REQ-022 m_valid = b_ovalid; m_data = b_odata; out_cnt increments on m_valid & m_ready.
REQ-023 m_last = m_valid & (out_cnt = nitems-1).
REQ-024 Push k of a job (1-indexed) SHALL emit item k-DEPTH; exactly nitems items are emitted and no bubble reaches m_valid.
REQ-025 DONE lasts one cycle: done=1, b_clr=1, then -> IDLE; the buffer is empty at the start of the next job.
REQ-026 start outside IDLE SHALL be ignored, with no latch and no state change.
REQ-027 A stall (m_ready=0 or s_valid=0 in RUN) SHALL freeze all counters and state; no data lost, duplicated or reordered.
REQ-028 Counters are NITEMS_W-bit unsigned; nitems = 2^NITEMS_W-1 SHALL complete without wrap.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, all counters to 0, and busy, done, s_ready, b_ivalid, m_last to 0, with b_data = 0 and b_clr = 1.
REQ-030 b_clr SHALL deassert on the first clock edge after rst returns high.
REQ-031 Reset mid-job SHALL abandon the job; the next job after release SHALL behave as from power-up.

Verification (DEPTH=3, STREAMW=32)
REQ-032 nitems=5, data 1..5, s_valid=m_ready=1 continuously -> 8 pushes; m_valid on pushes 4..8 with data 1..5; m_last with 5; done the cycle after push 8.
REQ-033 nitems=2, data 0xA,0xB -> 2 RUN pushes + 3 FLUSH pushes; m_data 0xA on push 4, 0xB on push 5 with m_last; done next cycle.
REQ-034 nitems=6, m_ready alternating 1,0 -> output 1..6 in order with no duplicates, b_ivalid never high while m_ready=0.
REQ-035 nitems=0 -> done pulses the cycle after start; b_ivalid never asserted; busy high for exactly one cycle.
REQ-036 rst pulsed low during RUN of nitems=10 -> outputs zero at once and b_clr=1; a subsequent job with nitems=4 yields exactly 4 correct items.
REQ-037 start re-asserted during RUN and FLUSH -> ignored; the latched nitems is unchanged and the job completes normally.
